pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It tracks the destination registers of the instructions in EX, MEM and WB, and compares them against the rs1/rs2 addresses decoded in ID. From that it generates stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It also produces EX-stage forwarding selects and freezes the whole pipeline while data memory is busy.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction (not a bubble).
- `id_rs1_addr`, `id_rs2_addr`  in  5 each  source registers of the ID instruction.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the ID instruction reads rs1 / rs2.
- `id_rd_addr`  in  5  destination register of the ID instruction.
- `id_reg_write`  in  1  the ID instruction writes rd.
- `id_dm_read`  in  1  the ID instruction is a load.
- `ex_branch_taken`  in  1  the branch/jump in EX resolved taken this cycle.
- `mem_busy`  in  1  data memory is not ready; MEM must hold.
- `pc_stall`  out  1  hold the PC.
- `if_id_stall`  out  1  hold IF/ID.
- `if_id_flush`  out  1  load NOP into IF/ID.
- `id_ex_bubble`  out  1  load NOP into ID/EX.
- `ex_mem_stall`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  2 each  EX operand source: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- `ctrl_state`  out  2  FSM state: 0 = RUN, 1 = RAW_STALL, 2 = MEM_WAIT.
- `stall_cycles`, `flush_count`  out  `CNT_W` each  performance counters.

## Operation
- Shadow slots EX, MEM, WB each hold {valid, rd, reg_write, is_load}.
- The shadow slots advance whenever `ex_mem_stall`=0:
  - EX receives the ID fields, or an invalid slot when `id_ex_bubble`=1.
  - MEM receives EX; WB receives MEM.
- Match(slot, rs) is true when all of these hold: slot valid, slot reg_write, rs≠0, rs used, `id_valid`, slot rd == rs.
- Control priority, highest first:
  1. `mem_busy`: assert `pc_stall`, `if_id_stall` and `ex_mem_stall`; flush and bubble are 0; state goes to MEM_WAIT; `ex_branch_taken` is ignored.
  2. `ex_branch_taken`: assert `if_id_flush` and `id_ex_bubble`; stalls are 0; any RAW stall is cancelled; `flush_count` increments.
  3. RAW hazard: assert `pc_stall`, `if_id_stall` and `id_ex_bubble`; state is RAW_STALL.
  4. Otherwise: all controls are 0 and state is RUN.
- Leaving MEM_WAIT: the first cycle with `mem_busy`=0 is evaluated as RUN, so a held `ex_branch_taken` or hazard takes effect that cycle.
- `stall_cycles` increments on every cycle where `pc_stall`=1.
- Both counters saturate at all-ones; they do not wrap.
- Forwarding selects are registered. On ID→EX advance with no bubble, for each operand:
  - select 1 if Match(EX slot), else 2 if Match(MEM slot), else 0.
  - The selects are zeroed when a bubble is inserted.
  - The selects hold while `ex_mem_stall`=1.

## Timing
- Stall, flush and bubble outputs are combinational from the current inputs and the shadow slots, so they are valid in the same cycle with 0-cycle latency.
- `ctrl_state`, the forwarding selects and the counters update at the clock edge.
- Reset values while `rst`=1 and after reset:
  - all shadow slots invalid, `ctrl_state`=RUN;
  - every stall/flush/bubble output 0, both `fwd_*_sel`=0;
  - both counters 0.
- Reset mid-stall: the next cycle is RUN with empty slots, and no residual stall.
- x0 never causes a hazard or a forward.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - RAW hazard = Match(EX slot) with EX is_load, i.e. load-use only.
  - This gives exactly 1 stall cycle per load-use.
  - Forwarding selects operate as described above.
- `HAZARD_FORWARD_EN` undefined:
  - RAW hazard = Match on any of the EX, MEM or WB slots. The register file does not bypass its write port, so a WB match must also stall.
  - Stall lasts up to 3 cycles, re-evaluated every cycle as bubbles advance.
  - `fwd_rs1_sel` and `fwd_rs2_sel` are tied to 0.

## Test plan
- Load-use: `lw x5` followed by `add x6,x5,x1`, with `HAZARD_FORWARD_EN` defined.
  - Required: exactly 1 cycle of `pc_stall`=`id_ex_bubble`=1.
  - Then `fwd_rs1_sel`=2 when the add is in EX; `stall_cycles`=1.
- Without forwarding: `addi x3,x0,1` followed by `sub x4,x3,x3`.
  - Required: 3 stall cycles, `fwd_*_sel` stays 0, `ctrl_state`=1 during the stall.
- Branch over hazard: `ex_branch_taken`=1 in the same cycle as a RAW match.
  - Required: `if_id_flush`=`id_ex_bubble`=1, `pc_stall`=0, `flush_count`=1.
- Memory wait: `mem_busy` held high for 4 cycles with a pending branch in EX.
  - Required: all three stalls high for 4 cycles, `ctrl_state`=2, no flush.
  - On the 5th cycle `if_id_flush`=1.
- x0 and reset:
  - `lw x0` followed by `add x1,x0,x0`: no stall.
  - Assert `rst` during a stall: all outputs 0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipe: stall, flush, bubble and forwarding selects.
// Optional feature macro HAZARD_FORWARD_EN: load-use-only stalls plus registered EX forwarding selects.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_reg_write,
  input  logic             id_dm_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RAW      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic slot_match(input slot_t s, input logic [4:0] rs,
                                      input logic used, input logic idv);
    return s.vld && s.rw && (rs != 5'd0) && used && idv && (s.rd == rs);
  endfunction

  state_t           state_q, state_d;
  slot_t            ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             m_ex1, m_ex2, m_mem1, m_mem2;
  logic             raw_hazard;
  logic             unused_bits;

  assign m_ex1  = slot_match(ex_q,  id_rs1_addr, id_rs1_used, id_valid);
  assign m_ex2  = slot_match(ex_q,  id_rs2_addr, id_rs2_used, id_valid);
  assign m_mem1 = slot_match(mem_q, id_rs1_addr, id_rs1_used, id_valid);
  assign m_mem2 = slot_match(mem_q, id_rs2_addr, id_rs2_used, id_valid);

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

  // With bypassing only a load in EX cannot be forwarded in time.
  assign raw_hazard  = ex_q.ld && (m_ex1 || m_ex2);
  assign unused_bits = mem_q.ld;

  always_comb begin
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    if (!ex_mem_stall) begin
      if (id_ex_bubble) begin
        fwd1_d = 2'd0;
        fwd2_d = 2'd0;
      end else begin
        fwd1_d = m_ex1 ? 2'd1 : (m_mem1 ? 2'd2 : 2'd0);
        fwd2_d = m_ex2 ? 2'd1 : (m_mem2 ? 2'd2 : 2'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_q <= 2'd0;
      fwd2_q <= 2'd0;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign fwd_rs1_sel = fwd1_q;
  assign fwd_rs2_sel = fwd2_q;
`else
  slot_t wb_q, wb_d;
  logic  m_wb1, m_wb2;

  // No bypass and no write-through register file: any in-flight writer stalls ID.
  assign m_wb1       = slot_match(wb_q, id_rs1_addr, id_rs1_used, id_valid);
  assign m_wb2       = slot_match(wb_q, id_rs2_addr, id_rs2_used, id_valid);
  assign raw_hazard  = m_ex1 | m_ex2 | m_mem1 | m_mem2 | m_wb1 | m_wb2;
  assign unused_bits = ^{ex_q.ld, mem_q.ld, wb_q.ld};

  always_comb begin
    wb_d = wb_q;
    if (!ex_mem_stall) begin
      wb_d = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign fwd_rs1_sel = 2'd0;
  assign fwd_rs2_sel = 2'd0;
`endif

  // Controls depend only on live inputs and slots, so the first cycle after MEM_WAIT acts as RUN.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;
    state_d      = ST_RUN;
    if (rst) begin
      state_d = ST_RUN;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      state_d      = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = ST_RUN;
    end else if (raw_hazard) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = ST_RAW;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!ex_mem_stall) begin
      ex_d  = id_ex_bubble ? slot_t'('0)
                           : '{vld: id_valid, rd: id_rd_addr, rw: id_reg_write, ld: id_dm_read};
      mem_d = ex_q;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_stall && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (if_id_flush && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow the build's HAZARD_FORWARD_EN setting.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_dm_read;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        ex_branch_taken, mem_busy;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel, ctrl_state;
  logic [31:0] stall_cycles, flush_count;
  logic        s_pc, s_ifs, s_iff, s_bub, s_ems;
  logic [1:0]  s_f1, s_f2, s_st;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  logic [4:0]  ctl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall};

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_dm_read(id_dm_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Narrow-counter instance shares the stimulus and exposes saturation quickly.
  pipe_hazard_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_dm_read(id_dm_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(s_pc), .if_id_stall(s_ifs), .if_id_flush(s_iff),
    .id_ex_bubble(s_bub), .ex_mem_stall(s_ems),
    .fwd_rs1_sel(s_f1), .fwd_rs2_sel(s_f2), .ctrl_state(s_st),
    .stall_cycles(s_stall_cnt), .flush_count(s_flush_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic       busy;
    logic [4:0] ctl;   // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall}
    logic [1:0] st;    // ctrl_state after the edge
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    id_valid     = v;
    id_rs1_addr  = rs1;
    id_rs1_used  = u1;
    id_rs2_addr  = rs2;
    id_rs2_used  = u2;
    id_rd_addr   = rd;
    id_reg_write = rw;
    id_dm_read   = ld;
  endtask

  task automatic do_reset(input string tag);
    rst             = 1'b1;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk({tag, " ctl in reset"}, 32'(ctl), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    chk({tag, " state after reset"}, 32'(ctrl_state), 32'd0);
    chk({tag, " stall_cycles after reset"}, stall_cycles, 32'd0);
    chk({tag, " flush_count after reset"}, flush_count, 32'd0);
    chk({tag, " fwd after reset"}, 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'd0);
  endtask

  initial begin
    int ns;
    vt[0] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0};
    vt[1] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0};
    vt[2] = '{1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00110, 2'd0};
    vt[3] = '{1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11001, 2'd2};
    vt[4] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'd0};
    vt[5] = '{1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11010, 2'd1};
    vt[6] = '{1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0};
    vt[7] = '{1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0};
    vt[8] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11001, 2'd2};
    vt[9] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0};

    do_reset("table");
    for (int i = 0; i < 10; i++) begin
      set_id(vt[i].v, vt[i].rs1, vt[i].u1, vt[i].rs2, vt[i].u2, vt[i].rd, vt[i].rw, vt[i].ld);
      ex_branch_taken = vt[i].br;
      mem_busy        = vt[i].busy;
      #1;
      chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vt[i].ctl));
      tick;
      chk($sformatf("vec%0d state", i), 32'(ctrl_state), 32'(vt[i].st));
    end
    chk("table stall_cycles", stall_cycles, 32'd3);
    chk("table flush_count", flush_count, 32'd1);

    // lw x5 ; add x6,x5,x1
    do_reset("loaduse");
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    chk("loaduse lw no stall", 32'(pc_stall), 32'd0);
    tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    ns = FWD ? 1 : 3;
    for (int k = 0; k <= ns; k++) begin
      #1;
      chk($sformatf("loaduse pc_stall k%0d", k), 32'(pc_stall), (k < ns) ? 32'd1 : 32'd0);
      chk($sformatf("loaduse bubble k%0d", k), 32'(id_ex_bubble), (k < ns) ? 32'd1 : 32'd0);
      tick;
    end
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("loaduse fwd_rs1_sel", 32'(fwd_rs1_sel), FWD ? 32'd2 : 32'd0);
    chk("loaduse fwd_rs2_sel", 32'(fwd_rs2_sel), 32'd0);
    chk("loaduse stall_cycles", stall_cycles, 32'(ns));

    // addi x3,x0,1 ; sub x4,x3,x3
    do_reset("raw");
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    chk("raw addi no stall", 32'(pc_stall), 32'd0);
    tick;
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic       st_exp;
      logic [1:0] f_exp;
      st_exp = !FWD && (k < 3);
      f_exp  = !FWD ? 2'd0 : ((k == 0) ? 2'd1 : ((k == 1) ? 2'd2 : 2'd0));
      #1;
      chk($sformatf("raw pc_stall k%0d", k), 32'(pc_stall), 32'(st_exp));
      tick;
      chk($sformatf("raw state k%0d", k), 32'(ctrl_state), 32'(st_exp));
      chk($sformatf("raw fwd1 k%0d", k), 32'(fwd_rs1_sel), 32'(f_exp));
      chk($sformatf("raw fwd2 k%0d", k), 32'(fwd_rs2_sel), 32'(f_exp));
    end

    // taken branch in the same cycle as a load-use hazard
    do_reset("branch");
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    chk("branch ctl", 32'(ctl), 32'b00110);
    tick;
    ex_branch_taken = 1'b0;
    chk("branch flush_count", flush_count, 32'd1);
    chk("branch stall_cycles", stall_cycles, 32'd0);
    chk("branch state", 32'(ctrl_state), 32'd0);

    // memory wait holding a taken branch for four cycles
    do_reset("memwait");
    ex_branch_taken = 1'b1;
    mem_busy        = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("memwait ctl k%0d", k), 32'(ctl), 32'b11001);
      tick;
      chk($sformatf("memwait state k%0d", k), 32'(ctrl_state), 32'd2);
    end
    mem_busy = 1'b0;
    #1;
    chk("memwait release ctl", 32'(ctl), 32'b00110);
    tick;
    ex_branch_taken = 1'b0;
    chk("memwait release state", 32'(ctrl_state), 32'd0);
    chk("memwait flush_count", flush_count, 32'd1);
    chk("memwait stall_cycles", stall_cycles, 32'd4);
    chk("memwait narrow stall saturates", 32'(s_stall_cnt), 32'd3);
    chk("memwait narrow flush", 32'(s_flush_cnt), 32'd1);

    // lw x0 ; add x1,x0,x0
    do_reset("x0");
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    #1;
    chk("x0 pc_stall", 32'(pc_stall), 32'd0);
    tick;
    chk("x0 fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'd0);
    chk("x0 stall_cycles", stall_cycles, 32'd0);

    // reset asserted in the middle of a load-use stall
    do_reset("rststall");
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    chk("rststall stall before reset", 32'(pc_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rststall ctl during reset", 32'(ctl), 32'd0);
    tick;
    rst = 1'b0;
    chk("rststall state", 32'(ctrl_state), 32'd0);
    chk("rststall counters", stall_cycles | flush_count, 32'd0);
    #1;
    chk("rststall no residual stall", 32'(ctl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
